// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame master: opcodes, frame geometry, FSM states.
package spi_frame_pkg;
    localparam logic [7:0] OP_CFG     = 8'h00;
    localparam logic [7:0] OP_SAMPLE  = 8'hFF;
    localparam int         N_WORDS    = 5;
    localparam int         FRAME_BITS = 88;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TGT,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_CS_HOLD
    } state_t;

    typedef enum logic {
        CMD_CFG    = 1'b0,
        CMD_SAMPLE = 1'b1
    } cmd_type_t;

    function automatic logic [7:0] opcode_of(input cmd_type_t t);
        return (t == CMD_SAMPLE) ? OP_SAMPLE : OP_CFG;
    endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// sclk phase divider: while enabled, emits a rise strobe after CLK_DIV cycles and a fall
// strobe after 2*CLK_DIV cycles, then restarts; held at the start of a bit while disabled.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic en,
    output logic rise,
    output logic fall
);
    localparam int            TOP    = 2 * CLK_DIV - 1;
    localparam int            CW     = $clog2(TOP + 1);
    localparam logic [CW-1:0] TOP_V  = CW'(TOP);
    localparam logic [CW-1:0] RISE_V = CW'(CLK_DIV);

    logic [CW-1:0] cnt;

    assign rise = en && (cnt == RISE_V);
    assign fall = en && (cnt == '0);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt <= TOP_V;
        end else if (!en || fall) begin
            cnt <= TOP_V;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 initiator sending one opcode byte plus five 16-bit words per command.
// Optional SPI_FULL_TIMEOUT_EN aborts a frame after TIMEOUT stalled cycles.
//
// state       | meaning
// ST_IDLE     | cs high, cmd_ready high, waiting for a command
// ST_WAIT_TGT | SAMPLE accepted, cs still high until foc_ready
// ST_CS_SETUP | cs low, sclk idle before the first bit
// ST_SHIFT    | clocking out the bits of one field
// ST_GAP      | sclk idle between fields; stalls while full_spi on the final gap cycle
// ST_CS_HOLD  | cs low after the last fall, then cs high with a done pulse
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int GAP_CYC  = 4,
    parameter int CS_SETUP = 2
`ifdef SPI_FULL_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 1024
`endif
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_type,
    input  logic [15:0] cmd_w0,
    input  logic [15:0] cmd_w1,
    input  logic [15:0] cmd_w2,
    input  logic [15:0] cmd_w3,
    input  logic [15:0] cmd_w4,
    input  logic        full_spi,
    input  logic        foc_ready,
    output logic        sclk,
    output logic        cs,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int TMAX = (GAP_CYC > CS_SETUP) ? GAP_CYC : CS_SETUP;
    localparam int TW   = $clog2(TMAX + 1);

    state_t                  state, nxt;
    logic [TW-1:0]           tmr;
    logic [3:0]              bit_left;
    logic [2:0]              field_left;
    logic [FRAME_BITS-1:0]   sr;
    logic                    sclk_en, sclk_rise, sclk_fall;
    logic                    field_end, timeout_hit;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk_sys(clk_sys),
        .rst    (rst),
        .en     (sclk_en),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    assign field_end = (state == ST_SHIFT) && sclk_fall && (bit_left == 4'd0);

`ifdef SPI_FULL_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_left;
    logic          stalling;

    assign stalling    = ((state == ST_WAIT_TGT) && !foc_ready) ||
                         ((state == ST_GAP) && (tmr == '0) && full_spi);
    assign timeout_hit = stalling && (stall_left == '0);

    always_ff @(posedge clk_sys) begin
        if (rst || !stalling) begin
            stall_left <= SW'(TIMEOUT - 1);
        end else if (stall_left != '0) begin
            stall_left <= stall_left - SW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    nxt = (cmd_type_t'(cmd_type) == CMD_SAMPLE && !foc_ready) ? ST_WAIT_TGT
                                                                              : ST_CS_SETUP;
                end
            end
            ST_WAIT_TGT: begin
                if (timeout_hit)    nxt = ST_IDLE;
                else if (foc_ready) nxt = ST_CS_SETUP;
            end
            ST_CS_SETUP: if (tmr == '0) nxt = ST_SHIFT;
            ST_SHIFT:    if (field_end) nxt = (field_left == 3'd0) ? ST_CS_HOLD : ST_GAP;
            ST_GAP: begin
                if (timeout_hit)                  nxt = ST_IDLE;
                else if (tmr == '0 && !full_spi)  nxt = ST_SHIFT;
            end
            ST_CS_HOLD:  if (tmr == '0) nxt = ST_IDLE;
            default:     nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        cs        = (state == ST_IDLE) || (state == ST_WAIT_TGT);
        sclk_en   = (state == ST_SHIFT);
        mosi      = cs ? 1'b0 : sr[FRAME_BITS-1];
    end

    assign busy = ~cmd_ready;

    // Datapath: shift register, bit/field counters, phase timer, sclk and status pulses.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            tmr        <= '0;
            bit_left   <= '0;
            field_left <= '0;
            sr         <= '0;
            sclk       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= (state == ST_CS_HOLD) && (tmr == '0);
            err  <= timeout_hit;

            if (state != ST_SHIFT)  sclk <= 1'b0;
            else if (sclk_rise)     sclk <= 1'b1;
            else if (sclk_fall)     sclk <= 1'b0;

            if (state == ST_IDLE && cmd_valid) begin
                sr         <= {opcode_of(cmd_type_t'(cmd_type)), cmd_w0, cmd_w1, cmd_w2, cmd_w3, cmd_w4};
                bit_left   <= 4'd7;
                field_left <= 3'(N_WORDS);
            end else if (state == ST_SHIFT && sclk_fall) begin
                sr <= {sr[FRAME_BITS-2:0], 1'b0};
                if (bit_left == 4'd0) begin
                    bit_left <= 4'd15;
                    if (field_left != 3'd0) field_left <= field_left - 3'd1;
                end else begin
                    bit_left <= bit_left - 4'd1;
                end
            end

            if (nxt != state) begin
                case (nxt)
                    ST_CS_SETUP, ST_CS_HOLD: tmr <= TW'(CS_SETUP - 1);
                    ST_GAP:                  tmr <= TW'(GAP_CYC - 1);
                    default:                 tmr <= '0;
                endcase
            end else if (tmr != '0) begin
                tmr <= tmr - TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: directed scenarios plus randomized frames, all checked against
// a frame-level timing/content model computed from the bench's own input history.
module tb_spi_frame_master;
    localparam int HMAX = 30000;
    localparam int CD   = 2;
    localparam int CSS  = 2;
    localparam int GAP  = 4;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_type = 1'b0, full_spi = 1'b0, foc_ready = 1'b1;
    logic [15:0] cmd_w0 = '0, cmd_w1 = '0, cmd_w2 = '0, cmd_w3 = '0, cmd_w4 = '0;
    logic        cmd_ready, sclk, cs, mosi, busy, done, err;

    spi_frame_master dut (
        .clk_sys(clk_sys), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_w0(cmd_w0), .cmd_w1(cmd_w1), .cmd_w2(cmd_w2),
        .cmd_w3(cmd_w3), .cmd_w4(cmd_w4), .full_spi(full_spi), .foc_ready(foc_ready),
        .sclk(sclk), .cs(cs), .mosi(mosi), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int total = 0, bad = 0;
    bit full_h [HMAX];
    bit rdy_h  [HMAX];
    bit rnd_en = 1'b0;

    // Frame model state
    bit          active = 0;
    int          f_acc, nrise, cs_first_low, cs_low_cnt;
    logic        f_type, prev_sclk = 1'b0, hold_bit;
    logic [87:0] f_bits, rx_bits, last_rx;
    int          rise_cyc [88];
    int          acc_cnt = 0, done_cnt = 0, last_acc = 0, last_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Close a frame at its done pulse: derive every expected timing from the input history.
    task automatic finalize();
        int e, g, s, f, nmis;
        int cum [6];
        e = f_acc;
        if (f_type) while (e < cyc && !rdy_h[e]) e++;
        cum[0] = 0;
        for (int j = 0; j < 5; j++) begin
            g = e + CSS + 2*CD*(8 + 16*j) + GAP*(j + 1) + cum[j];
            s = g;
            while (s < cyc && full_h[s]) s++;
            cum[j+1] = cum[j] + (s - g);
        end
        chk("rise_count", nrise, 88);
        nmis = 0;
        for (int i = 0; i < 88 && i < nrise; i++) begin
            f = (i < 8) ? 0 : 1 + (i - 8) / 16;
            if (rise_cyc[i] != e + 1 + CSS + (2*i + 1)*CD + GAP*f + cum[f]) nmis++;
        end
        chk("rise_times_bad", nmis, 0);
        chk("done_cyc", cyc, e + 1 + CSS + 2*CD*88 + GAP*5 + CSS + cum[5]);
        chk("cs_first_low", cs_first_low, e + 1);
        chk("cs_low_cnt", cs_low_cnt, cyc - e - 1);
        chk("cs_at_done", cs, 1);
        last_done = cyc;
        last_rx   = rx_bits;
        active    = 0;
        done_cnt++;
    endtask

    initial begin
        forever begin
            @(negedge clk_sys);
            if (cyc < HMAX) begin
                full_h[cyc] = full_spi;
                rdy_h[cyc]  = foc_ready;
            end
            if (rst) begin
                active    = 0;
                prev_sclk = 1'b0;
                continue;
            end
            chk("busy", busy, !cmd_ready);
            chk("err", err, 0);
            if (cs) chk("sclk_cs_high", sclk, 0);
            if (!active) begin
                chk("cs_idle", cs, 1);
                chk("mosi_idle", mosi, 0);
            end
            if (active) begin
                if (!cs) begin
                    if (cs_first_low < 0) cs_first_low = cyc;
                    cs_low_cnt++;
                end
                if (sclk && !prev_sclk) begin
                    if (nrise < 88) begin
                        chk($sformatf("bit%0d", nrise), mosi, f_bits[87-nrise]);
                        rx_bits[87-nrise] = mosi;
                        rise_cyc[nrise]   = cyc;
                    end
                    nrise++;
                    hold_bit = mosi;
                end else if (sclk) begin
                    chk("mosi_stable", mosi, hold_bit);
                end
                if (done) finalize();
                else if (cyc - f_acc > 5000) begin
                    chk("frame_timeout", 0, 1);
                    active = 0;
                end
            end else if (done) begin
                chk("done_spurious", done, 0);
            end
            prev_sclk = sclk;
            if (cmd_valid && cmd_ready) begin
                active       = 1;
                f_acc        = cyc;
                f_type       = cmd_type;
                f_bits       = {(cmd_type ? 8'hFF : 8'h00), cmd_w0, cmd_w1, cmd_w2, cmd_w3, cmd_w4};
                rx_bits      = '0;
                nrise        = 0;
                cs_first_low = -1;
                cs_low_cnt   = 0;
                last_acc     = cyc;
                acc_cnt++;
            end
        end
    end

    // Random backpressure / target-ready activity, each run capped well below any timeout.
    initial begin
        int run_f, run_r;
        run_f = 0;
        run_r = 0;
        forever begin
            @(posedge clk_sys); #1;
            if (rnd_en) begin
                if ($urandom_range(7) == 0 || (full_spi && run_f > 40)) full_spi = ~full_spi;
                if ($urandom_range(7) == 0 || (!foc_ready && run_r > 40)) foc_ready = ~foc_ready;
                run_f = full_spi ? run_f + 1 : 0;
                run_r = foc_ready ? 0 : run_r + 1;
            end
        end
    end

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic issue(input logic t, input logic [15:0] a, b, c, d, e, input bit keep);
        int n0;
        n0 = acc_cnt;
        cmd_type = t; cmd_w0 = a; cmd_w1 = b; cmd_w2 = c; cmd_w3 = d; cmd_w4 = e;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3000 && acc_cnt == n0; k++) begin
            @(posedge clk_sys); #1;
        end
        chk("accept_wait", acc_cnt != n0, 1);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic issue_rand(input logic t, input bit keep);
        issue(t, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), keep);
    endtask

    task automatic wait_done();
        int n0;
        n0 = done_cnt;
        for (int k = 0; k < 6000 && done_cnt == n0; k++) begin
            @(posedge clk_sys); #1;
        end
        chk("done_wait", done_cnt != n0, 1);
    endtask

    initial begin
        int a;
        repeat (3) @(posedge clk_sys);
        #1 rst = 1'b0;
        chk("rst_cs", cs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk_sys);
        #1;

        // CFG frame with known words
        issue(1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0F00, 1'b0);
        wait_done();
        chk("cfg_len", last_done - last_acc, 377);
        chk("cfg_bits", last_rx, 88'h00_1111_2222_3333_4444_0F00);

        // SAMPLE while the target is not ready
        foc_ready = 1'b0;
        issue_rand(1'b1, 1'b0);
        a = last_acc;
        at_cyc(a + 25);
        chk("wait_cs", cs, 1);
        chk("wait_busy", busy, 1);
        at_cyc(a + 50);
        foc_ready = 1'b1;
        wait_done();
        chk("sample_len", last_done - last_acc, 427);
        chk("sample_op", last_rx[87:80], 8'hFF);

        // full_spi stall across the second gap
        issue_rand(1'b0, 1'b0);
        a = last_acc;
        at_cyc(a + 100);
        full_spi = 1'b1;
        at_cyc(a + 120);
        chk("stall_sclk", sclk, 0);
        chk("stall_cs", cs, 0);
        at_cyc(a + 136);
        full_spi = 1'b0;
        wait_done();
        chk("stall_len", last_done - last_acc, 407);

        // reset in the middle of a word
        issue_rand(1'b1, 1'b0);
        a = last_acc;
        at_cyc(a + 262);
        rst = 1'b1;
        @(posedge clk_sys); #1;
        rst = 1'b0;
        chk("midrst_cs", cs, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_done", done, 0);
        issue_rand(1'b0, 1'b0);
        wait_done();
        chk("post_rst_len", last_done - last_acc, 377);

        // back-to-back commands
        issue_rand(1'b0, 1'b1);
        issue_rand(1'b1, 1'b0);
        chk("b2b_cs_gap", last_acc, last_done);
        wait_done();
        chk("b2b_len", last_done - last_acc, 377);

        // randomized frames under random backpressure and target-ready activity
        rnd_en = 1'b1;
        for (int n = 0; n < 16; n++) begin
            issue_rand(1'($urandom_range(1)), 1'b0);
            wait_done();
            repeat ($urandom_range(3)) @(posedge clk_sys);
            #1;
        end
        rnd_en = 1'b0;
        @(posedge clk_sys); #1;
        full_spi  = 1'b0;
        foc_ready = 1'b1;
        repeat (5) @(posedge clk_sys);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
